decode_stage: RTL and testbench

//  Parametrised instruction-decode stage: decodes the IF/ID instruction, reads a bypassed register

---
 rtl/cpu_pkg.sv | 77 +++++++
 rtl/decode_regfile.sv | 39 +++
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcodes, ALU command and branch encodings, control word.
package cpu_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    typedef enum logic [3:0] {
        EXE_NOP = 4'd0,
        EXE_ADD = 4'd1,
        EXE_SUB = 4'd2,
        EXE_AND = 4'd3,
        EXE_OR  = 4'd4,
        EXE_NOR = 4'd5,
        EXE_XOR = 4'd6,
        EXE_SLL = 4'd7,
        EXE_SRA = 4'd8,
        EXE_SRL = 4'd9
    } exe_cmd_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_t;

    typedef struct packed {
        exe_cmd_t exe_cmd;
        logic     mem_write;
        logic     mem_read;
        logic     writeback_en;
        br_type_t br_type;
        logic     is_immediate;
    } ctrl_t;

    // Unlisted opcodes fall through to the all-zero control word (a NOP).
    function automatic ctrl_t decode(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_ADD:  begin c.exe_cmd = EXE_ADD; c.writeback_en = 1'b1; end
            OP_SUB:  begin c.exe_cmd = EXE_SUB; c.writeback_en = 1'b1; end
            OP_AND:  begin c.exe_cmd = EXE_AND; c.writeback_en = 1'b1; end
            OP_OR:   begin c.exe_cmd = EXE_OR;  c.writeback_en = 1'b1; end
            OP_NOR:  begin c.exe_cmd = EXE_NOR; c.writeback_en = 1'b1; end
            OP_XOR:  begin c.exe_cmd = EXE_XOR; c.writeback_en = 1'b1; end
            OP_SLL:  begin c.exe_cmd = EXE_SLL; c.writeback_en = 1'b1; end
            OP_SRA:  begin c.exe_cmd = EXE_SRA; c.writeback_en = 1'b1; end
            OP_SRL:  begin c.exe_cmd = EXE_SRL; c.writeback_en = 1'b1; end
            OP_ADDI: begin c.exe_cmd = EXE_ADD; c.writeback_en = 1'b1; c.is_immediate = 1'b1; end
            OP_SUBI: begin c.exe_cmd = EXE_SUB; c.writeback_en = 1'b1; c.is_immediate = 1'b1; end
            OP_LD:   begin c.exe_cmd = EXE_ADD; c.mem_read = 1'b1; c.writeback_en = 1'b1; c.is_immediate = 1'b1; end
            OP_ST:   begin c.exe_cmd = EXE_ADD; c.mem_write = 1'b1; c.is_immediate = 1'b1; end
            OP_BEZ:  begin c.br_type = BR_BEZ; c.is_immediate = 1'b1; end
            OP_BNE:  begin c.br_type = BR_BNE; c.is_immediate = 1'b1; end
            OP_JMP:  begin c.br_type = BR_JMP; c.is_immediate = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file with two combinational read ports, one write port and write-to-read bypass.
module decode_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_dest != '0) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // A write landing this cycle is visible to the decoder without waiting for the edge.
    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == '0)                       rdata1 = '0;
        else if (wb_en && wb_dest == raddr1)    rdata1 = wb_data;

        rdata2 = regs[raddr2];
        if (raddr2 == '0)                       rdata2 = '0;
        else if (wb_en && wb_dest == raddr2)    rdata2 = wb_data;
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decode, bypassed register read, hazard stall and ID/EXE register
// with valid/ready flow control and branch flush.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int FORWARD_EN = 1,
    localparam int REG_AW    = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [XLEN-1:0]   pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              exe_wb_en,
    input  logic              mem_wb_en,
    input  logic              exe_mem_read,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [3:0]        exe_cmd,
    output logic              mem_write,
    output logic              mem_read,
    output logic              writeback_en,
    output logic [1:0]        br_type,
    output logic [XLEN-1:0]   alu_inp1,
    output logic [XLEN-1:0]   alu_inp2,
    output logic [XLEN-1:0]   reg2,
    output logic [REG_AW-1:0] idexe_dest,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic              hazard
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] src1, src2, rd;
    logic [XLEN-1:0]   rdata1, rdata2, imm_ext;
    ctrl_t             ctrl;
    logic              src1_used, src2_used, stall1, stall2;

    assign opcode  = instruction[31:26];
    assign src1    = instruction[21 +: REG_AW];
    assign src2    = instruction[16 +: REG_AW];
    assign rd      = instruction[11 +: REG_AW];
    assign imm_ext = XLEN'($signed(instruction[15:0]));
    assign ctrl    = decode(opcode);

    decode_regfile #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_dest (wb_dest),
        .wb_data (wb_data),
        .raddr1  (src1),
        .raddr2  (src2),
        .rdata1  (rdata1),
        .rdata2  (rdata2)
    );

    // Stores and conditional branches carry an immediate but still read src2.
    assign src1_used = (opcode != OP_NOP) && (opcode != OP_JMP);
    assign src2_used = !ctrl.is_immediate || (opcode == OP_ST) ||
                       (opcode == OP_BEZ) || (opcode == OP_BNE);

    always_comb begin
        if (FORWARD_EN != 0) begin
            stall1 = exe_mem_read && exe_wb_en && (exe_dest == src1);
            stall2 = exe_mem_read && exe_wb_en && (exe_dest == src2);
        end else begin
            stall1 = (exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1);
            stall2 = (exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2);
        end
        hazard = in_valid && ((src1_used && src1 != '0 && stall1) ||
                              (src2_used && src2 != '0 && stall2));
    end

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            exe_cmd      <= '0;
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
            writeback_en <= 1'b0;
            br_type      <= '0;
            alu_inp1     <= '0;
            alu_inp2     <= '0;
            reg2         <= '0;
            idexe_dest   <= '0;
            src1_out     <= '0;
            src2_out     <= '0;
        end else if (flush || (!(out_valid && !out_ready) && !(in_valid && in_ready))) begin
            // Killed or empty slot: a bubble must never carry side-effecting controls.
            out_valid    <= 1'b0;
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
            writeback_en <= 1'b0;
            br_type      <= '0;
        end else if (in_valid && in_ready) begin
            out_valid    <= 1'b1;
            out_pc       <= pc;
            exe_cmd      <= ctrl.exe_cmd;
            mem_write    <= ctrl.mem_write;
            mem_read     <= ctrl.mem_read;
            writeback_en <= ctrl.writeback_en;
            br_type      <= ctrl.br_type;
            alu_inp1     <= rdata1;
            alu_inp2     <= ctrl.is_immediate ? imm_ext : rdata2;
            reg2         <= rdata2;
            idexe_dest   <= ctrl.is_immediate ? src2 : rd;
            src1_out     <= src1;
            src2_out     <= src2;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: forwarding instance plus a no-forwarding instance
// for the stall-on-any-RAW variant.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic        mw;
        logic        mr;
        logic        wb;
        logic [1:0]  br;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] r2;
        logic [4:0]  dest;
        logic [4:0]  s1;
        logic [4:0]  s2;
    } exp_t;

    logic        clock, reset;
    logic        in_valid, flush, wb_en, exe_wb_en, mem_wb_en, exe_mem_read, out_ready;
    logic [31:0] instruction, pc, wb_data;
    logic [4:0]  wb_dest, exe_dest, mem_dest;

    logic        in_ready, out_valid, mem_write, mem_read, writeback_en, hazard;
    logic [31:0] out_pc, alu_inp1, alu_inp2, reg2;
    logic [3:0]  exe_cmd;
    logic [1:0]  br_type;
    logic [4:0]  idexe_dest, src1_out, src2_out;

    logic        nf_in_ready, nf_out_valid, nf_mem_write, nf_mem_read, nf_writeback_en, nf_hazard;
    logic [31:0] nf_out_pc, nf_alu_inp1, nf_alu_inp2, nf_reg2;
    logic [3:0]  nf_exe_cmd;
    logic [1:0]  nf_br_type;
    logic [4:0]  nf_idexe_dest, nf_src1_out, nf_src2_out;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic [31:0] regs_m [32];

    decode_stage #(.XLEN(32), .NUM_REGS(32), .FORWARD_EN(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .flush(flush), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .exe_dest(exe_dest), .mem_dest(mem_dest),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_read(exe_mem_read),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .exe_cmd(exe_cmd),
        .mem_write(mem_write), .mem_read(mem_read), .writeback_en(writeback_en),
        .br_type(br_type), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .reg2(reg2),
        .idexe_dest(idexe_dest), .src1_out(src1_out), .src2_out(src2_out), .hazard(hazard)
    );

    decode_stage #(.XLEN(32), .NUM_REGS(32), .FORWARD_EN(0)) dut_nf (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(nf_in_ready),
        .instruction(instruction), .pc(pc), .flush(flush), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .exe_dest(exe_dest), .mem_dest(mem_dest),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_read(exe_mem_read),
        .out_ready(out_ready), .out_valid(nf_out_valid), .out_pc(nf_out_pc),
        .exe_cmd(nf_exe_cmd), .mem_write(nf_mem_write), .mem_read(nf_mem_read),
        .writeback_en(nf_writeback_en), .br_type(nf_br_type), .alu_inp1(nf_alu_inp1),
        .alu_inp2(nf_alu_inp2), .reg2(nf_reg2), .idexe_dest(nf_idexe_dest),
        .src1_out(nf_src1_out), .src2_out(nf_src2_out), .hazard(nf_hazard)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference register file.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_m[i] <= 32'h0;
        end else if (wb_en && wb_dest != 5'd0) begin
            regs_m[wb_dest] <= wb_data;
        end
    end

    function automatic logic [31:0] rd_m(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_en && wb_dest == a) return wb_data;
        return regs_m[a];
    endfunction

    function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] s1,
                                           input logic [4:0] s2, input logic [4:0] d);
        return {op, s1, s2, d, 11'h0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s1,
                                           input logic [4:0] s2, input logic [15:0] imm);
        return {op, s1, s2, imm};
    endfunction

    // Opcodes: ADD=1 SUB=3 ADDI=32 LD=36 ST=37 BNE=41; ALU cmd ADD=1 SUB=2; branch BNE=2.
    function automatic exp_t exp_from(input logic [31:0] ins, input logic [31:0] p);
        exp_t       e;
        logic [5:0] op;
        logic       imm_f;
        op    = ins[31:26];
        imm_f = 1'b0;
        e     = '0;
        e.pc  = p;
        case (op)
            6'd1:    begin e.cmd = 4'd1; e.wb = 1'b1; end
            6'd3:    begin e.cmd = 4'd2; e.wb = 1'b1; end
            6'd32:   begin e.cmd = 4'd1; e.wb = 1'b1; imm_f = 1'b1; end
            6'd36:   begin e.cmd = 4'd1; e.mr = 1'b1; e.wb = 1'b1; imm_f = 1'b1; end
            6'd37:   begin e.cmd = 4'd1; e.mw = 1'b1; imm_f = 1'b1; end
            6'd41:   begin e.br = 2'd2; imm_f = 1'b1; end
            default: ;
        endcase
        e.a1   = rd_m(ins[25:21]);
        e.r2   = rd_m(ins[20:16]);
        e.a2   = imm_f ? {{16{ins[15]}}, ins[15:0]} : e.r2;
        e.dest = imm_f ? ins[20:16] : ins[15:11];
        e.s1   = ins[25:21];
        e.s2   = ins[20:16];
        return e;
    endfunction

    function automatic exp_t got();
        return {out_pc, exe_cmd, mem_write, mem_read, writeback_en, br_type,
                alu_inp1, alu_inp2, reg2, idexe_dest, src1_out, src2_out};
    endfunction

    // One clock: account handshakes in the scoreboard, then check the registered output.
    task automatic tick();
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(exp_from(instruction, pc));
        end
        @(posedge clock);
        #1;
        if (out_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL out_check: out_valid=1 with no expected entry, got %h", got());
            end else if (got() !== exp_q[0]) begin
                fails++;
                $display("FAIL out_check: got %h expected %h", got(), exp_q[0]);
            end
        end
    endtask

    task automatic wb_write(input logic [4:0] d, input logic [31:0] v);
        wb_en = 1'b1; wb_dest = d; wb_data = v;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (out_valid !== 1'b0 || writeback_en !== 1'b0 || alu_inp1 !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b wb=%b a1=%h expected 0", out_valid, writeback_en, alu_inp1);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        wb_write(5'd3, 32'h55);
        in_valid = 1'b1; pc = 32'h40; instruction = r_type(6'd1, 5'd3, 5'd3, 5'd5);
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL pre_reset_valid: out_valid=%b expected 1", out_valid);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || writeback_en !== 1'b0 || alu_inp1 !== 32'h0 || out_pc !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: out_valid=%b wb=%b a1=%h pc=%h expected 0", out_valid, writeback_en, alu_inp1, out_pc);
        end
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        in_valid = 1'b1; pc = 32'h44; instruction = r_type(6'd1, 5'd3, 5'd0, 5'd6);
        tick();
        in_valid = 1'b0;
        tests++;
        if (alu_inp1 !== 32'h0) begin
            fails++; $display("FAIL reset_regfile: r3 read %h expected 0", alu_inp1);
        end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_dest = 5'd3; wb_data = 32'h1234;
        in_valid = 1'b1; pc = 32'h100; instruction = r_type(6'd1, 5'd3, 5'd4, 5'd5);
        tick();
        wb_en = 1'b0;
        tests++;
        if (alu_inp1 !== 32'h1234 || idexe_dest !== 5'd5) begin
            fails++;
            $display("FAIL bypass: a1=%h dest=%0d expected 1234 and 5", alu_inp1, idexe_dest);
        end
        pc = 32'h104; instruction = r_type(6'd3, 5'd3, 5'd0, 5'd6);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_load_use();
        wb_write(5'd7, 32'h77);
        wb_write(5'd2, 32'h22);
        exe_dest = 5'd7; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        in_valid = 1'b1; pc = 32'h200; instruction = r_type(6'd1, 5'd7, 5'd2, 5'd1);
        #1;
        tests++;
        if (hazard !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL load_use_stall: hazard=%b in_ready=%b expected 1/0", hazard, in_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || writeback_en !== 1'b0) begin
            fails++; $display("FAIL load_use_bubble: out_valid=%b wb=%b expected 0/0", out_valid, writeback_en);
        end
        exe_mem_read = 1'b0;
        #1;
        tests++;
        if (hazard !== 1'b0 || nf_hazard !== 1'b1) begin
            fails++; $display("FAIL alu_raw: fwd hazard=%b nofwd hazard=%b expected 0/1", hazard, nf_hazard);
        end
        exe_wb_en = 1'b0;
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL load_use_issue: out_valid=%b expected 1", out_valid);
        end
        exe_dest = 5'd0;
    endtask

    task automatic test_raw_noforward();
        mem_dest = 5'd2; mem_wb_en = 1'b1;
        in_valid = 1'b1; instruction = r_type(6'd1, 5'd2, 5'd3, 5'd1);
        #1;
        tests++;
        if (nf_hazard !== 1'b1 || nf_in_ready !== 1'b0 || hazard !== 1'b0) begin
            fails++;
            $display("FAIL mem_raw: nofwd hazard=%b ready=%b fwd hazard=%b expected 1/0/0", nf_hazard, nf_in_ready, hazard);
        end
        instruction = i_type(6'd32, 5'd4, 5'd2, 16'h5);
        #1;
        tests++;
        if (nf_hazard !== 1'b0) begin
            fails++; $display("FAIL imm_dest_no_stall: hazard=%b expected 0", nf_hazard);
        end
        mem_dest = 5'd0; exe_dest = 5'd0; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        instruction = r_type(6'd1, 5'd0, 5'd0, 5'd1);
        #1;
        tests++;
        if (nf_hazard !== 1'b0 || hazard !== 1'b0) begin
            fails++; $display("FAIL r0_no_stall: nofwd=%b fwd=%b expected 0/0", nf_hazard, hazard);
        end
        in_valid = 1'b0; mem_wb_en = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] held_pc;
        in_valid = 1'b1; pc = 32'h300; instruction = r_type(6'd3, 5'd7, 5'd2, 5'd8);
        tick();
        held_pc = out_pc;
        out_ready = 1'b0;
        pc = 32'h304; instruction = i_type(6'd37, 5'd7, 5'd2, 16'h8010);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_ready: cycle %0d in_ready=%b expected 0", i, in_ready);
            end
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_pc !== held_pc) begin
                fails++; $display("FAIL stall_hold: cycle %0d valid=%b pc=%h expected 1 %h", i, out_valid, out_pc, held_pc);
            end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_pc !== 32'h304 || mem_write !== 1'b1 || alu_inp2 !== 32'hFFFF8010) begin
            fails++; $display("FAIL resume_store: pc=%h mw=%b a2=%h expected 304 1 ffff8010", out_pc, mem_write, alu_inp2);
        end
        tick();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; pc = 32'h400; instruction = r_type(6'd1, 5'd7, 5'd7, 5'd10);
        tick();
        flush = 1'b1; pc = 32'h404; instruction = r_type(6'd1, 5'd2, 5'd2, 5'd11);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL flush_ready: in_ready=%b expected 0", in_ready);
        end
        tick();
        flush = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || writeback_en !== 1'b0) begin
            fails++; $display("FAIL flush_kill: out_valid=%b wb=%b expected 0/0", out_valid, writeback_en);
        end
        pc = 32'h500; instruction = i_type(6'd32, 5'd0, 5'd9, 16'hFFFF);
        tick();
        in_valid = 1'b0;
        tests++;
        if (alu_inp2 !== 32'hFFFFFFFF || idexe_dest !== 5'd9 || mem_write !== 1'b0) begin
            fails++; $display("FAIL addi_sext: a2=%h dest=%0d mw=%b expected ffffffff 9 0", alu_inp2, idexe_dest, mem_write);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7];
        ops[0] = 6'd1; ops[1] = 6'd3; ops[2] = 6'd32; ops[3] = 6'd36;
        ops[4] = 6'd37; ops[5] = 6'd41; ops[6] = 6'd63;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pc = 32'h600 + 32'(i * 4);
            instruction = {ops[$urandom_range(0, 6)], 26'($urandom)};
            wb_en = 1'($urandom); wb_dest = 5'($urandom); wb_data = $urandom;
            tick();
            tests++;
            if (out_valid !== 1'b1) begin
                fails++; $display("FAIL back_to_back: cycle %0d out_valid=%b expected 1", i, out_valid);
            end
        end
        in_valid = 1'b0; wb_en = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; exe_wb_en = 1'b0;
        mem_wb_en = 1'b0; exe_mem_read = 1'b0; out_ready = 1'b1;
        instruction = 32'h0; pc = 32'h0; wb_data = 32'h0;
        wb_dest = 5'd0; exe_dest = 5'd0; mem_dest = 5'd0;
        test_reset();
        test_bypass();
        test_load_use();
        test_raw_noforward();
        test_backpressure();
        test_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
